// File: rtl/riscv_soft_alu_arbiter_pkg.sv
// Shared definitions for the soft ALU and its two-port arbiter: opcode encoding.
package riscv_soft_alu_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int OP_W      = 4;

    // Opcodes 4'hE and 4'hF are left undefined and evaluate to zero.
    typedef enum logic [OP_W-1:0] {
        ALU_OP_ADD  = 4'h0,
        ALU_OP_SUB  = 4'h1,
        ALU_OP_SLL  = 4'h2,
        ALU_OP_SRL  = 4'h3,
        ALU_OP_SRA  = 4'h4,
        ALU_OP_AND  = 4'h5,
        ALU_OP_OR   = 4'h6,
        ALU_OP_XOR  = 4'h7,
        ALU_OP_SLT  = 4'h8,
        ALU_OP_SLTU = 4'h9,
        ALU_OP_SEQ  = 4'hA,
        ALU_OP_SNE  = 4'hB,
        ALU_OP_SGE  = 4'hC,
        ALU_OP_SGEU = 4'hD
    } alu_op_e;

endpackage

// File: rtl/riscv_soft_alu_arbiter_alu.sv
// Purely combinational integer ALU shared behind the arbiter.
module riscv_soft_alu
    import riscv_soft_alu_arbiter_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic [OP_W-1:0]    op_i,
    input  logic [XPR_LEN-1:0] a_i,
    input  logic [XPR_LEN-1:0] b_i,
    output logic [XPR_LEN-1:0] result_o
);
    localparam int SHW = $clog2(XPR_LEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    // Evaluate the selected operation; compares yield a zero-extended flag.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_OP_ADD:  result_o = a_i + b_i;
            ALU_OP_SUB:  result_o = a_i - b_i;
            ALU_OP_SLL:  result_o = a_i << shamt;
            ALU_OP_SRL:  result_o = a_i >> shamt;
            ALU_OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OP_AND:  result_o = a_i & b_i;
            ALU_OP_OR:   result_o = a_i | b_i;
            ALU_OP_XOR:  result_o = a_i ^ b_i;
            ALU_OP_SLT:  result_o = {{(XPR_LEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_OP_SLTU: result_o = {{(XPR_LEN-1){1'b0}}, a_i < b_i};
            ALU_OP_SEQ:  result_o = {{(XPR_LEN-1){1'b0}}, a_i == b_i};
            ALU_OP_SNE:  result_o = {{(XPR_LEN-1){1'b0}}, a_i != b_i};
            ALU_OP_SGE:  result_o = {{(XPR_LEN-1){1'b0}}, $signed(a_i) >= $signed(b_i)};
            ALU_OP_SGEU: result_o = {{(XPR_LEN-1){1'b0}}, a_i >= b_i};
            default:     result_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_soft_alu_arbiter.sv
// Two-port arbiter in front of one soft ALU with a single registered result slot.
// Port 0 is the execute stage, port 1 the branch/address unit.
module riscv_soft_alu_arbiter
    import riscv_soft_alu_arbiter_pkg::*;
#(
    parameter int XPR_LEN        = 32,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*OP_W-1:0]      req_op,
    input  logic [2*XPR_LEN-1:0]   req_a,
    input  logic [2*XPR_LEN-1:0]   req_b,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [XPR_LEN-1:0]     resp_result
);
    logic               full_q, full_d;
    logic               owner_q, owner_d;
    logic               rr_last_q, rr_last_d;
    logic [XPR_LEN-1:0] result_q, result_d;

    logic [1:0]         grant;
    logic               can_accept;
    logic               sel;
    logic               accept;
    logic [OP_W-1:0]    alu_op;
    logic [XPR_LEN-1:0] alu_a, alu_b, alu_y;

    // Pick a winner from the valid requests; on a tie round-robin favours the port that did not win last.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (FIXED_PRIORITY || rr_last_q) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // The slot can take a new result when empty or when its owner drains it this cycle.
    assign can_accept = !full_q || resp_ready[owner_q];
    assign req_ready  = (reset_n && can_accept) ? grant : 2'b00;
    assign accept     = |req_ready;
    assign sel        = grant[1];

    assign alu_op = sel ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
    assign alu_a  = sel ? req_a[2*XPR_LEN-1:XPR_LEN] : req_a[XPR_LEN-1:0];
    assign alu_b  = sel ? req_b[2*XPR_LEN-1:XPR_LEN] : req_b[XPR_LEN-1:0];

    riscv_soft_alu #(.XPR_LEN(XPR_LEN)) u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_y)
    );

    // Slot next state: refill on accept (even while draining), otherwise empty on drain.
    always_comb begin
        full_d    = full_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        result_d  = result_q;
        if (accept) begin
            full_d    = 1'b1;
            owner_d   = sel;
            rr_last_d = sel;
            result_d  = alu_y;
        end else if (full_q && resp_ready[owner_q]) begin
            full_d    = 1'b0;
        end
    end

    // Slot and round-robin registers; reset overrides any pending handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q    <= 1'b0;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            result_q  <= '0;
        end else begin
            full_q    <= full_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            result_q  <= result_d;
        end
    end

    assign resp_valid  = {full_q & owner_q, full_q & ~owner_q};
    assign resp_result = result_q;

endmodule
